// File: rtl/cpu_pkg.sv
// Shared definitions for the architectural register file and its scoreboard.
//   DATA_W  register width
//   NREGS   number of architectural registers (last index is the zero register)
//   ADDR_W  register index width
//   XZR     index of the hardwired zero register
package cpu_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned ADDR_W = $clog2(NREGS);

  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t XZR = reg_idx_t'(NREGS - 1);

  // True when an enabled port targets the given register index.
  function automatic logic port_hits(input logic en, input reg_idx_t addr,
                                     input reg_idx_t idx);
    return en && (addr == idx);
  endfunction

endpackage

// File: rtl/regfile_entry.sv
// One architectural register: a data word plus its busy flag.
//   clk, rst  clock and asynchronous active-high reset
//   wr        commit wr_data into the word on this edge
//   wr_data   value to commit
//   set       a new producer claims this register (wins over clr)
//   clr       the pending producer retires
//   data      stored word
//   busy      pending-producer flag
module regfile_entry
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              set,
  input  logic              clr,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  // Data word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (wr) begin
      data <= wr_data;
    end
  end

  // Busy flag: a newly issued producer supersedes the one retiring this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
    end else if (set) begin
      busy <= 1'b1;
    end else if (clr) begin
      busy <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// 32 x 64-bit architectural register file with per-register busy scoreboard.
//   clk, rst             clock and asynchronous active-high reset
//   rd_addr_a/b          read port indices
//   rd_data_a/b          read data (combinational, writeback-bypassed)
//   rd_busy_a/b          pending-producer status of the read registers
//   wr_en/addr/data      writeback from the execute/memory path
//   iss_en/iss_addr      destination claimed by an issuing instruction
//   busy_vec             full scoreboard, bit i = register i busy
module regfile_scoreboard
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic [NREGS-1:0]  busy_vec
);

  logic [DATA_W-1:0] data_q [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic              wr_live;

  // A writeback to the zero register never lands anywhere.
  assign wr_live = wr_en && (wr_addr != XZR);

  // Real registers X0..X30.
  for (genvar i = 0; i < NREGS - 1; i++) begin : g_entry
    regfile_entry u_entry (
      .clk     (clk),
      .rst     (rst),
      .wr      (port_hits(wr_en, wr_addr, reg_idx_t'(i))),
      .wr_data (wr_data),
      .set     (port_hits(iss_en, iss_addr, reg_idx_t'(i))),
      .clr     (port_hits(wr_en, wr_addr, reg_idx_t'(i))),
      .data    (data_q[i]),
      .busy    (busy_q[i])
    );
  end

  // XZR: constant zero, never busy.
  assign data_q[NREGS-1] = '0;
  assign busy_q[NREGS-1] = 1'b0;

  // Read port A: bypass the in-flight writeback, force zero during reset.
  always_comb begin
    rd_data_a = '0;
    rd_busy_a = 1'b0;
    if (!rst) begin
      rd_data_a = (wr_live && (wr_addr == rd_addr_a)) ? wr_data : data_q[rd_addr_a];
      rd_busy_a = busy_q[rd_addr_a] && !port_hits(wr_en, wr_addr, rd_addr_a);
    end
  end

  // Read port B: same structure as port A.
  always_comb begin
    rd_data_b = '0;
    rd_busy_b = 1'b0;
    if (!rst) begin
      rd_data_b = (wr_live && (wr_addr == rd_addr_b)) ? wr_data : data_q[rd_addr_b];
      rd_busy_b = busy_q[rd_addr_b] && !port_hits(wr_en, wr_addr, rd_addr_b);
    end
  end

  // Busy bits already clear asynchronously on reset.
  assign busy_vec = busy_q;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- 32-entry × 64-bit architectural register file (LEGv8 X0–X31) with a per-register busy scoreboard.
- Built from 64-bit reset-able register words.
- Consumes writeback data from the execute/memory path and feeds operands plus busy status to the decode/issue stage.
- X31 (XZR) is hardwired to zero and is never busy.

Parameters:
- DATA_W, 64, register width in bits.
- NREGS, 32, number of architectural registers; index NREGS-1 is the zero register.
- ADDR_W, 5, register index width, equal to log2(NREGS).

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- rd_addr_a  input  ADDR_W  read port A index.
- rd_addr_b  input  ADDR_W  read port B index.
- rd_data_a  output  DATA_W  read port A data.
- rd_data_b  output  DATA_W  read port B data.
- rd_busy_a  output  1  register A has a pending producer.
- rd_busy_b  output  1  register B has a pending producer.
- wr_en  input  1  writeback valid.
- wr_addr  input  ADDR_W  writeback destination.
- wr_data  input  DATA_W  writeback value.
- iss_en  input  1  issue of an instruction with a destination register.
- iss_addr  input  ADDR_W  destination being claimed.
- busy_vec  output  NREGS  full scoreboard, bit i = register i busy.

Behaviour:
- Reset:
  - Asynchronous, active-high. On assertion, all 32 data words and all busy bits go to 0 immediately, with no clock edge needed.
  - All outputs read 0 while rst is high.
  - Reset mid-operation discards any in-flight write or issue on that edge.
- Storage: one DATA_W register per index. A write commits on the rising clk edge when wr_en=1 and wr_addr≠31.
- Zero register:
  - Writes to 31 are ignored.
  - Reads of 31 return 0 and busy=0.
  - iss_en with iss_addr=31 sets nothing.
- Reads:
  - Combinational, zero latency.
  - Write-through bypass: if wr_en=1, wr_addr≠31 and wr_addr==rd_addr_x, then rd_data_x = wr_data in the same cycle. Otherwise rd_data_x is the stored value.
  - Both ports may read the same index.
- Scoreboard, per register i≠31, evaluated at each rising edge:
  - set = iss_en && iss_addr==i.
  - clr = wr_en && wr_addr==i.
  - next busy[i] = set ? 1 : (clr ? 0 : busy[i]). Set wins over a simultaneous clear, because the new producer supersedes the retiring one.
- Busy read bypass: rd_busy_x = busy[rd_addr_x] && !(wr_en && wr_addr==rd_addr_x). A register being written this cycle reads as not busy and carries the bypassed data. The same-cycle issue set is not reflected until the next cycle.
- Writeback to a non-busy register is legal. It updates data, and busy stays 0.
- No overflow or underflow conditions exist; each busy bit is a single flag, not a counter.

Decomposition:
- Shared package (cpu_pkg):
  - DATA_W, NREGS, ADDR_W.
  - Constant XZR = 5'd31.
  - A typedef for the register index.
- Sub-module: `regfile_entry`, one 64-bit data word plus its busy flip-flop, each with async reset. Instantiate it 31 times via a generate loop; index 31 is a tied-off constant.
- Read muxing and the bypass stay in the top module.

Test Plan:
- Reset: pulse rst high mid-cycle after writing X5=64'hDEAD_BEEF → rd_data_a(5)=0 and busy_vec=0 immediately, before the next clk edge.
- Write then read: wr X3=64'h0123_4567_89AB_CDEF; next cycle rd_addr_a=3 → rd_data_a=64'h0123_4567_89AB_CDEF, rd_busy_a=0.
- Bypass: same cycle wr_en, wr_addr=7, wr_data=64'h42, rd_addr_b=7 → rd_data_b=64'h42 combinationally; X7 busy beforehand → rd_busy_b=0 in that cycle.
- XZR: wr X31=64'hFFFF…FFFF, then iss X31 → rd X31 = 0, busy_vec[31]=0.
- Scoreboard: iss X10 → busy_vec[10]=1 next cycle; wr X10=64'h99 → busy_vec[10]=0 next cycle. Simultaneous iss X10 and wr X10 → data=64'h99 and busy_vec[10]=1.
- Dual-port / same index: X12=64'h55; rd_addr_a=rd_addr_b=12 → both ports return 64'h55; random 1000-cycle traffic compared against a reference model with no mismatches.
